// File: rtl/mips_register_file.sv
// -----------------------------------------------------------------------------
// mips_register_file
//   General-purpose register file of the Mini-MIPS datapath. Two combinational
//   read ports (rs, rt) feed the ALU operands; one write-back port commits on
//   the rising clock edge. Register 0 is hardwired to zero and has no storage.
//
//   Optional build macro: REGFILE_BYPASS_EN
//     defined   -> a qualifying same-cycle write is forwarded to a read port
//                  that addresses the register being written
//     undefined -> read ports reflect stored state only
//
//   Ports
//     clk      : clock, state updates on rising edge
//     reset_n  : asynchronous active-low reset, clears all registers
//     rs_addr  : read port A address        rs_data : read port A data
//     rt_addr  : read port B address        rt_data : read port B data
//     wr_en    : write-back enable
//     wr_addr  : write-back destination register
//     wr_data  : write-back value
// -----------------------------------------------------------------------------
module mips_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    // Storage exists only for registers 1..NUM_REGS-1; register 0 reads as zero.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    // A write that will actually change state at the next edge.
    logic wr_hit;
    assign wr_hit = reset_n && wr_en && (wr_addr != '0);

    // Write-back port with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_addr == ADDR_WIDTH'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Stored-state read muxes; address 0 falls through to zero.
    logic [DATA_WIDTH-1:0] rs_stored;
    logic [DATA_WIDTH-1:0] rt_stored;

    always_comb begin
        rs_stored = '0;
        rt_stored = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs_addr == ADDR_WIDTH'(i)) begin
                rs_stored = regs[i];
            end
            if (rt_addr == ADDR_WIDTH'(i)) begin
                rt_stored = regs[i];
            end
        end
    end

    // Output select; reset forces zero even if the bypass would otherwise hit.
    always_comb begin
        rs_data = rs_stored;
        rt_data = rt_stored;
`ifdef REGFILE_BYPASS_EN
        // wr_hit already excludes address 0 and reset, so r0 is never forwarded.
        if (wr_hit && (rs_addr == wr_addr)) begin
            rs_data = wr_data;
        end
        if (wr_hit && (rt_addr == wr_addr)) begin
            rt_data = wr_data;
        end
`endif
        if (!reset_n) begin
            rs_data = '0;
            rt_data = '0;
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// -----------------------------------------------------------------------------
// tb_mips_register_file
//   Self-checking bench for mips_register_file. A plain array model of the
//   architectural registers is compared against both read ports on every
//   falling clock edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_register_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] rs_addr, rt_addr, wr_addr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rs_data, rt_data;

    mips_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural model: 32 words, index 0 kept at zero.
    logic [DW-1:0] model [32];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (wr_en && wr_addr != 0) begin
            model[wr_addr] = wr_data;
        end
    end

    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
        if (!reset_n || a == 0) return '0;
        if (BYPASS && wr_en && wr_addr != 0 && a == wr_addr) return wr_data;
        return model[a];
    endfunction

    // Continuous compare against the model, mid-cycle.
    always @(negedge clk) begin
        check("rs_model", rs_data, expect_rd(rs_addr));
        check("rt_model", rt_data, expect_rd(rt_addr));
    end

    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd; rs_addr = ra; rt_addr = rb;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Every address reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, '0, '0, AW'(i), AW'(31 - i));
            #1;
            check("reset_rs", rs_data, 32'h0);
            check("reset_rt", rt_data, 32'h0);
        end

        // Consecutive writes to r1 and r2.
        step(1'b1, 5'd1, 32'hAAAA_AAAA, 5'd0, 5'd0);
        step(1'b1, 5'd2, 32'h5555_5555, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        #1;
        check("r1_rd", rs_data, 32'hAAAA_AAAA);
        check("r2_rd", rt_data, 32'h5555_5555);

        // r0 write is discarded and disturbs nothing.
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        check("r0_same_cycle_rs", rs_data, 32'h0);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        check("r0_rs", rs_data, 32'h0);
        check("r0_rt", rt_data, 32'h0);
        step(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        #1;
        check("r1_kept", rs_data, 32'hAAAA_AAAA);
        check("r2_kept", rt_data, 32'h5555_5555);

        // Same-cycle read of the register being written.
        step(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd0);
        #1;
        check("r5_pre_edge", rs_data, BYPASS ? 32'h1234_5678 : 32'h0);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        check("r5_post_rs", rs_data, 32'h1234_5678);
        check("r5_post_rt", rt_data, 32'h1234_5678);

        // Fill r1..r31, then asynchronous reset between edges.
        for (int i = 1; i < 32; i++) step(1'b1, AW'(i), 32'hFFFF_FFFF, AW'(i), 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
        #1;
        check("fill_r7", rs_data, 32'hFFFF_FFFF);
        check("fill_r31", rt_data, 32'hFFFF_FFFF);
        reset_n = 1'b0;
        #1;
        check("async_rst_rs", rs_data, 32'h0);
        check("async_rst_rt", rt_data, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEAD_BEEF; rs_addr = 5'd9;
        #1;
        check("rst_blocks_bypass", rs_data, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_en = 1'b0; rs_addr = 5'd7; rt_addr = 5'd9;
        #1;
        check("r7_after_rst", rs_data, 32'h0);
        check("r9_write_in_rst", rt_data, 32'h0);

        // Disabled write, then enabled write to r3.
        step(1'b0, 5'd3, 32'h0000_FFFF, 5'd3, 5'd3);
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        check("r3_no_we", rs_data, 32'h0);
        step(1'b1, 5'd3, 32'h0000_FFFF, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        check("r3_we_rs", rs_data, 32'h0000_FFFF);
        check("r3_we_rt", rt_data, 32'h0000_FFFF);

        // Randomized traffic with occasional reset cycles.
        for (int n = 0; n < 2000; n++) begin
            logic [AW-1:0] wa;
            @(posedge clk);
            #1;
            wa      = AW'($urandom_range(31));
            reset_n = ($urandom_range(63) != 0);
            wr_en   = ($urandom_range(3) != 0);
            wr_addr = wa;
            wr_data = $urandom;
            rs_addr = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(31));
            rt_addr = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(31));
        end
        @(posedge clk);
        #1 reset_n = 1'b1; wr_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
